// File: rtl/kahan_accum_mc.sv
// kahan_accum_mc: multi-channel streaming Kahan accumulator with a 4-stage
// interleaved update pipeline and a credit-protected output FIFO.
// Optional feature macro: KAHAN_FP_ADDER_EN (use floating_point_adder instances
// instead of modular integer add/subtract on the raw vectors).
module kahan_accum_mc #(
    parameter int EXP_WIDTH_I  = 5,
    parameter int MANT_WIDTH_I = 2,
    parameter int NUM_CH_I     = 4,
    parameter int OUT_DEPTH_I  = 4,
    localparam int BIT_WIDTH_I = 1 + EXP_WIDTH_I + MANT_WIDTH_I,
    localparam int CH_W        = (NUM_CH_I > 1) ? $clog2(NUM_CH_I) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic [CH_W-1:0]        in_ch_i,
    input  logic [BIT_WIDTH_I-1:0] in_elem_i,
    input  logic                   in_last_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [CH_W-1:0]        out_ch_o,
    output logic [BIT_WIDTH_I-1:0] out_sum_o,
    output logic [BIT_WIDTH_I-1:0] out_c_o
);
    localparam int BW  = BIT_WIDTH_I;
    localparam int NCH = 1 << CH_W;
    localparam int PW  = (OUT_DEPTH_I > 1) ? $clog2(OUT_DEPTH_I) : 1;
    localparam int OW  = $clog2(OUT_DEPTH_I + 1);
    localparam int CW  = OW + 2;
    localparam int EW  = CH_W + 2 * BW;

    logic [NCH-1:0]  busy_q;
    logic [BW-1:0]   sum_q [NCH];
    logic [BW-1:0]   c_q   [NCH];

    logic            s1_v, s1_last, s2_v, s2_last, s3_v, s3_last;
    logic [CH_W-1:0] s1_ch, s2_ch, s3_ch;
    logic [BW-1:0]   s1_y, s2_y, s2_t, s2_sum, s3_y, s3_t, s3_tms;
    logic [BW-1:0]   y_d, t_d, tms_d, c_d;

    logic [EW-1:0]   mem_q [OUT_DEPTH_I];
    logic [PW-1:0]   wr_q, rd_q;
    logic [OW-1:0]   occ_q;
    logic [1:0]      inflight;
    logic [CW-1:0]   credit;
    logic            accept, push, pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH_I - 1)) ? '0 : p + 1'b1;
    endfunction

`ifdef KAHAN_FP_ADDER_EN
    floating_point_adder #(.EXP_WIDTH(EXP_WIDTH_I), .MANT_WIDTH(MANT_WIDTH_I)) u_s1 (
        .a(in_elem_i), .b(c_q[in_ch_i]), .subtract(1'b1), .y(y_d)
    );
    floating_point_adder #(.EXP_WIDTH(EXP_WIDTH_I), .MANT_WIDTH(MANT_WIDTH_I)) u_s2 (
        .a(sum_q[s1_ch]), .b(s1_y), .subtract(1'b0), .y(t_d)
    );
    floating_point_adder #(.EXP_WIDTH(EXP_WIDTH_I), .MANT_WIDTH(MANT_WIDTH_I)) u_s3 (
        .a(s2_t), .b(s2_sum), .subtract(1'b1), .y(tms_d)
    );
    floating_point_adder #(.EXP_WIDTH(EXP_WIDTH_I), .MANT_WIDTH(MANT_WIDTH_I)) u_s4 (
        .a(s3_tms), .b(s3_y), .subtract(1'b1), .y(c_d)
    );
`else
    assign y_d   = in_elem_i - c_q[in_ch_i];
    assign t_d   = sum_q[s1_ch] + s1_y;
    assign tms_d = s2_t - s2_sum;
    assign c_d   = s3_tms - s3_y;
`endif

    // Credit = last elements still in the pipeline plus entries already queued;
    // a last element is only admitted while a FIFO slot is guaranteed for it.
    assign inflight   = 2'(s1_v && s1_last) + 2'(s2_v && s2_last) + 2'(s3_v && s3_last);
    assign credit     = CW'(inflight) + CW'(occ_q);
    assign in_ready_o = !busy_q[in_ch_i] && (!in_last_i || credit < CW'(OUT_DEPTH_I));
    assign accept     = in_valid_i && in_ready_o;
    assign push       = s3_v && s3_last;
    assign pop        = out_valid_o && out_ready_i;
    assign out_valid_o = occ_q != '0;
    assign {out_ch_o, out_sum_o, out_c_o} = mem_q[rd_q];

    // Stage valid bits; reset discards everything in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v <= 1'b0;
            s2_v <= 1'b0;
            s3_v <= 1'b0;
        end else begin
            s1_v <= accept;
            s2_v <= s1_v;
            s3_v <= s2_v;
        end
    end

    // Stage payloads: channel, last flag, y and the captured sum ride along.
    always_ff @(posedge clk_i) begin
        s1_ch   <= in_ch_i;
        s1_last <= in_last_i;
        s1_y    <= y_d;
        s2_ch   <= s1_ch;
        s2_last <= s1_last;
        s2_y    <= s1_y;
        s2_t    <= t_d;
        s2_sum  <= sum_q[s1_ch];
        s3_ch   <= s2_ch;
        s3_last <= s2_last;
        s3_y    <= s2_y;
        s3_t    <= s2_t;
        s3_tms  <= tms_d;
    end

    // Per-channel state: writeback from S4, busy set on accept and cleared at writeback.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                sum_q[i] <= '0;
                c_q[i]   <= '0;
            end
        end else begin
            if (s3_v) begin
                sum_q[s3_ch]  <= s3_last ? '0 : s3_t;
                c_q[s3_ch]    <= s3_last ? '0 : c_d;
                busy_q[s3_ch] <= 1'b0;
            end
            if (accept) busy_q[in_ch_i] <= 1'b1;
        end
    end

    // Output FIFO; credit accounting means a push never meets a full FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
            for (int i = 0; i < OUT_DEPTH_I; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= {s3_ch, s3_t, c_d};
                wr_q        <= inc(wr_q);
            end
            if (pop) rd_q <= inc(rd_q);
            occ_q <= occ_q + OW'(push) - OW'(pop);
        end
    end
endmodule

// File: tb/tb_kahan_accum_mc.sv
// tb_kahan_accum_mc: randomized scoreboard bench for kahan_accum_mc (default build).
module tb_kahan_accum_mc;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       in_valid_i = 1'b0;
    logic       in_last_i = 1'b0;
    logic       out_ready_i = 1'b1;
    logic [1:0] in_ch_i = 2'd0;
    logic [7:0] in_elem_i = 8'd0;
    logic       in_ready_o, out_valid_o;
    logic [1:0] out_ch_o;
    logic [7:0] out_sum_o, out_c_o;

    int          tests = 0;
    int          errs = 0;
    bit          rnd_rdy = 1'b0;
    int          msum [4];
    logic [17:0] exp_q [$];
    logic [17:0] mon_e;

    kahan_accum_mc dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_ch_i(in_ch_i),
        .in_elem_i(in_elem_i), .in_last_i(in_last_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_ch_o(out_ch_o), .out_sum_o(out_sum_o), .out_c_o(out_c_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_i);
        if (rnd_rdy) out_ready_i = 1'($urandom_range(0, 1));
    endtask

    // Offer one element from a negedge; returns at the negedge after acceptance.
    task automatic send(input int ch, input int e, input bit last, output int waited);
        in_valid_i = 1'b1;
        in_ch_i    = 2'(ch);
        in_elem_i  = 8'(e);
        in_last_i  = last;
        waited     = 0;
        #1;
        while (!in_ready_o && waited < 64) begin
            tick();
            #1;
            waited++;
        end
        if (!in_ready_o) begin
            check("accept_timeout", int'(in_ready_o), 1);
            in_valid_i = 1'b0;
            return;
        end
        msum[ch] = (msum[ch] + e) % 256;
        if (last) begin
            exp_q.push_back({2'(ch), 8'(msum[ch]), 8'd0});
            msum[ch] = 0;
        end
        @(posedge clk_i);
        tick();
        in_valid_i = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 4; i++) msum[i] = 0;
        tick();
        rst_i = 1'b0;
    endtask

    // Monitor: every handshake on the output pops one expected result.
    always begin
        @(negedge clk_i);
        #1;
        if (!rst_i && out_valid_o && out_ready_i) begin
            if (exp_q.size() == 0) check("unexpected_output", 1, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("out_ch", int'(out_ch_o), int'(mon_e[17:16]));
                check("out_sum", int'(out_sum_o), int'(mon_e[15:8]));
                check("out_c", int'(out_c_o), int'(mon_e[7:0]));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int hi;
        for (int i = 0; i < 4; i++) msum[i] = 0;
        tick();
        tick();
        rst_i = 1'b0;
        #1;
        check("rst_out_valid", int'(out_valid_o), 0);
        check("rst_out_ch", int'(out_ch_o), 0);
        check("rst_out_sum", int'(out_sum_o), 0);
        check("rst_out_c", int'(out_c_o), 0);
        check("rst_ready", int'(in_ready_o), 1);
        in_last_i = 1'b1;
        #1;
        check("rst_ready_last", int'(in_ready_o), 1);
        in_last_i = 1'b0;
        tick();

        send(0, 3, 1'b0, w); check("t1_wait0", w, 0);
        send(0, 5, 1'b0, w); check("t1_wait1", w, 3);
        send(0, 7, 1'b1, w); check("t1_wait2", w, 3);
        tick(); tick(); #1;
        check("t1_not_yet", int'(out_valid_o), 0);
        tick(); #1;
        check("t1_valid", int'(out_valid_o), 1);
        check("t1_sum", int'(out_sum_o), 15);
        repeat (4) tick();

        for (int r = 0; r < 3; r++)
            for (int ch = 0; ch < 4; ch++) begin
                send(ch, ch + 1, r == 2, w);
                check("t2_ready", w, 0);
            end
        repeat (8) tick();

        send(1, 200, 1'b0, w);
        send(1, 100, 1'b1, w);
        send(1, 5, 1'b1, w);
        repeat (10) tick();

        out_ready_i = 1'b0;
        for (int ch = 0; ch < 4; ch++) send(ch, 10 + ch, 1'b1, w);
        in_ch_i   = 2'd0;
        in_last_i = 1'b1;
        repeat (6) tick();
        #1;
        check("t4_held", int'(in_ready_o), 0);
        in_ch_i   = 2'd2;
        in_last_i = 1'b0;
        #1;
        check("t4_ch2_nonlast", int'(in_ready_o), 1);
        tick();
        out_ready_i = 1'b1;
        in_ch_i     = 2'd0;
        in_last_i   = 1'b1;
        #1;
        check("t4_pop_cycle", int'(in_ready_o), 0);
        tick();
        out_ready_i = 1'b0;
        #1;
        check("t4_freed", int'(in_ready_o), 1);
        send(0, 20, 1'b1, w);
        check("t4_fifth_wait", w, 0);
        out_ready_i = 1'b1;
        repeat (12) tick();

        rnd_rdy = 1'b1;
        for (int n = 0; n < 300; n++)
            send($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 3) == 0, w);
        rnd_rdy = 1'b0;
        out_ready_i = 1'b1;
        repeat (20) tick();

        send(0, 1, 1'b0, w);
        send(1, 2, 1'b0, w);
        send(2, 3, 1'b1, w);
        do_reset();
        hi = 0;
        repeat (10) begin
            tick();
            #1;
            hi += int'(out_valid_o);
        end
        check("t5_no_output", hi, 0);
        send(0, 9, 1'b1, w);
        check("t5_ready_after", w, 0);
        repeat (8) tick();

        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
